cdu_pulse_gen: RTL and testbench
================================

Name: cdu_pulse_gen

Overview:
- Multi-channel read-counter pulse generator for the CDU.
- Each channel holds a mirror of the angle the AGC has been told about, compares it with the digitised angle from that channel's tracking loop, and emits +/- count pulses on ATpPGH/ATmPGH to walk the mirror toward the target along the shortest path.
- Generalises the single-axis pulse output to NCH time-slotted channels, with parametrised angle width, slot length and pulse width, plus a zero mode and a tracking status flag.

Parameters:
- NCH, 3, number of angle channels (1..8).
- W, 16, angle word width; 1 LSB = 360/2^W deg; mirror wraps modulo 2^W.
- SLOT_LEN, 4, CLOCKH cycles per channel slot; frame = NCH*SLOT_LEN cycles.
- PULSE_W, 2, pulse high time in cycles (1 <= PULSE_W <= SLOT_LEN).
- TRK_TH, 2, tracking threshold: trk[i]=1 when |error| <= TRK_TH LSB.

Ports:
- CLOCKH  input  1  block clock (51.2 kHz AGC clock), rising-edge.
- rst_n  input  1  reset, asynchronous, active-low.
- en  input  1  pulse enable; 0 = no new pulses, mirrors frozen.
- zero_req  input  1  zero CDU: 1 = clear mirrors and suppress pulses.
- ang_in  input  NCH*W  target angles; channel i at [i*W +: W].
- ATpPGH  output  NCH  plus-count pulse per channel.
- ATmPGH  output  NCH  minus-count pulse per channel.
- mirror  output  NCH*W  current mirror value per channel.
- trk  output  NCH  per-channel tracking flag.

Behaviour:
- Reset (rst_n=0, async):
  - ATpPGH=0, ATmPGH=0, mirror=0, trk=0.
  - Slot counter=0, pulse timers=0.
- Slot counter free-runs 0..NCH*SLOT_LEN-1 and wraps; channel i owns cycles [i*SLOT_LEN, (i+1)*SLOT_LEN).
- Error: err_i = (ang_in_i - mirror_i) mod 2^W, interpreted as a W-bit signed value.
- Decision at the first cycle of slot i, when en=1 and zero_req=0, using ang_in sampled that cycle:
  - err_i>0: on the next edge ATpPGH[i]=1 and mirror_i += 1 (mod 2^W).
  - err_i<0: on the next edge ATmPGH[i]=1 and mirror_i -= 1 (mod 2^W).
  - err_i = -2^(W-1) (exact half turn): treated as positive, plus pulse.
  - err_i=0: no pulse.
- Pulse shape:
  - High for exactly PULSE_W cycles, then low for the rest of the slot.
  - At most one pulse per channel per frame; max slew is 1 LSB per frame per channel.
  - ATpPGH[i] and ATmPGH[i] are never both 1.
- Mirror update happens on the same edge the pulse rises; the mirror output is registered.
- trk[i]: registered, updated every cycle from the current err_i; trk[i]=1 iff |err_i| <= TRK_TH. The half-turn value counts as magnitude 2^(W-1).
- en=0:
  - No new pulses start.
  - A pulse already high completes its PULSE_W width.
  - Mirrors hold.
- zero_req=1, effective from the next edge:
  - All mirrors = 0.
  - All pulse outputs forced low, truncating any in-flight pulse; its mirror step is discarded by the clear.
  - Slot counter keeps running.
  - trk still computed, against mirror=0.
- zero_req 1->0: decisions resume at the next slot start belonging to each channel; mirror slews up from 0.
- Simultaneous zero_req=1 and a slot-start decision: zero wins; no pulse, mirror=0.
- ang_in change mid-slot affects only the next decision for that channel; trk follows within 1 cycle.
- Reset asserted mid-pulse: outputs drop asynchronously; after release, the frame restarts at slot 0.

Test Plan:
- Reset/idle: NCH=3, W=16, SLOT_LEN=4, PULSE_W=2, ang_in all 0, en=1 -> no pulses for 100 cycles; mirror=0; trk=3'b111.
- Plus slew: ch0 ang_in=5 -> exactly 5 ATpPGH[0] pulses, each 2 cycles wide, starting at cycles 1, 13, 25, 37, 49 after the first slot-0 start; then mirror0=5, trk[0]=1; ch1/ch2 silent.
- Wrap/shortest path: ch1 ang_in=16'hFFFD from mirror 0 -> 3 ATmPGH[1] pulses in slot-1 positions; mirror1=16'hFFFD. Half turn: ch2 ang_in=16'h8000 from 0 -> plus pulses, first decision plus.
- Zero mid-pulse: ch0 slewing toward 100, assert zero_req during the first cycle of a high pulse -> ATpPGH[0] low next edge; mirror all 0; no pulses while asserted. Release -> slew restarts from 0 and reaches 100 after 100 frames.
- Enable gating: en=0 while error=10 -> no pulses, mirror constant, trk[i]=0. en=1 -> pulses resume at that channel's next slot start.
- Async reset mid-operation: assert rst_n=0 between edges while a pulse is high -> ATpPGH/ATmPGH/mirror/trk=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/cdu_pulse_gen.sv
// CDU read-counter pulse generator: per-channel mirror angles slewed toward
// the tracking-loop angles by time-slotted +/- count pulses.
module cdu_pulse_gen #(
  parameter int unsigned NCH      = 3,
  parameter int unsigned W        = 16,
  parameter int unsigned SLOT_LEN = 4,
  parameter int unsigned PULSE_W  = 2,
  parameter int unsigned TRK_TH   = 2
) (
  input  logic             CLOCKH,
  input  logic             rst_n,
  input  logic             en,
  input  logic             zero_req,
  input  logic [NCH*W-1:0] ang_in,
  output logic [NCH-1:0]   ATpPGH,
  output logic [NCH-1:0]   ATmPGH,
  output logic [NCH*W-1:0] mirror,
  output logic [NCH-1:0]   trk
);

  localparam int unsigned SW  = (SLOT_LEN > 1) ? $clog2(SLOT_LEN) : 1;
  localparam int unsigned CHW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned TW  = (PULSE_W > 1) ? $clog2(PULSE_W) : 1;

  logic [SW-1:0]  r_sub;
  logic [CHW-1:0] r_ch;
  logic [W-1:0]   r_mirror [NCH];
  logic [TW-1:0]  r_tmr    [NCH];
  logic [NCH-1:0] r_p;
  logic [NCH-1:0] r_m;
  logic [NCH-1:0] r_trk;

  logic [W-1:0]   w_err [NCH];
  logic [W-1:0]   w_mag [NCH];
  logic [NCH-1:0] w_decide;
  logic [NCH-1:0] w_up;
  logic [NCH-1:0] w_dn;
  logic [NCH-1:0] w_trk_nxt;
  logic           w_slot_start;

  // Frame position split into owning channel and cycle-within-slot
  always_ff @(posedge CLOCKH or negedge rst_n) begin
    if (!rst_n) begin
      r_sub <= '0;
      r_ch  <= '0;
    end else if (r_sub == SW'(SLOT_LEN - 1)) begin
      r_sub <= '0;
      r_ch  <= (r_ch == CHW'(NCH - 1)) ? '0 : r_ch + CHW'(1);
    end else begin
      r_sub <= r_sub + SW'(1);
    end
  end

  assign w_slot_start = (r_sub == '0);

  // Shortest-path error; the exact half turn resolves to a plus step
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      w_err[i]     = ang_in[i*W +: W] - r_mirror[i];
      w_mag[i]     = w_err[i][W-1] ? (~w_err[i] + W'(1)) : w_err[i];
      w_trk_nxt[i] = (w_mag[i] <= W'(TRK_TH));
      w_decide[i]  = en && !zero_req && w_slot_start && (r_ch == CHW'(i));
      w_up[i]      = w_decide[i] && (w_err[i] != '0) &&
                     (!w_err[i][W-1] || (w_err[i] == {1'b1, {(W-1){1'b0}}}));
      w_dn[i]      = w_decide[i] && w_err[i][W-1] &&
                     (w_err[i] != {1'b1, {(W-1){1'b0}}});
    end
  end

  // Pulse timers and mirrors; zero_req clears everything including in-flight pulses
  always_ff @(posedge CLOCKH or negedge rst_n) begin
    if (!rst_n) begin
      r_p   <= '0;
      r_m   <= '0;
      r_trk <= '0;
      for (int i = 0; i < NCH; i++) begin
        r_mirror[i] <= '0;
        r_tmr[i]    <= '0;
      end
    end else begin
      r_trk <= w_trk_nxt;
      for (int i = 0; i < NCH; i++) begin
        if (zero_req) begin
          r_p[i]      <= 1'b0;
          r_m[i]      <= 1'b0;
          r_tmr[i]    <= '0;
          r_mirror[i] <= '0;
        end else if (w_up[i]) begin
          r_p[i]      <= 1'b1;
          r_m[i]      <= 1'b0;
          r_tmr[i]    <= TW'(PULSE_W - 1);
          r_mirror[i] <= r_mirror[i] + W'(1);
        end else if (w_dn[i]) begin
          r_p[i]      <= 1'b0;
          r_m[i]      <= 1'b1;
          r_tmr[i]    <= TW'(PULSE_W - 1);
          r_mirror[i] <= r_mirror[i] - W'(1);
        end else if (r_tmr[i] != '0) begin
          r_tmr[i]    <= r_tmr[i] - TW'(1);
        end else begin
          r_p[i]      <= 1'b0;
          r_m[i]      <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    mirror = '0;
    for (int i = 0; i < NCH; i++) begin
      mirror[i*W +: W] = r_mirror[i];
    end
  end

  assign ATpPGH = r_p;
  assign ATmPGH = r_m;
  assign trk    = r_trk;

endmodule

// File: tb/tb_cdu_pulse_gen.sv
// Directed bench for cdu_pulse_gen (NCH=3, W=16, SLOT_LEN=4, PULSE_W=2, TRK_TH=2).
module tb_cdu_pulse_gen;
  localparam int unsigned NCH = 3;
  localparam int unsigned W   = 16;
  localparam int unsigned FR  = 12;

  logic             CLOCKH = 1'b0;
  logic             rst_n;
  logic             en;
  logic             zero_req;
  logic [NCH*W-1:0] ang_in;
  logic [NCH-1:0]   ATpPGH;
  logic [NCH-1:0]   ATmPGH;
  logic [NCH*W-1:0] mirror;
  logic [NCH-1:0]   trk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc;
  int hi_p [NCH];
  int hi_m [NCH];
  int rise_p [NCH];
  int both_hi = 0;
  int shape_err;
  logic [NCH-1:0] prev_p;

  cdu_pulse_gen #(.NCH(3), .W(16), .SLOT_LEN(4), .PULSE_W(2), .TRK_TH(2)) dut (
    .CLOCKH  (CLOCKH),
    .rst_n   (rst_n),
    .en      (en),
    .zero_req(zero_req),
    .ang_in  (ang_in),
    .ATpPGH  (ATpPGH),
    .ATmPGH  (ATmPGH),
    .mirror  (mirror),
    .trk     (trk)
  );

  always #5 CLOCKH = ~CLOCKH;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] mir(input int ch);
    return mirror[ch*W +: W];
  endfunction

  task automatic clear_stats();
    for (int i = 0; i < NCH; i++) begin
      hi_p[i] = 0; hi_m[i] = 0; rise_p[i] = 0;
    end
  endtask

  task automatic step();
    @(posedge CLOCKH);
    #1;
    cyc++;
    for (int i = 0; i < NCH; i++) begin
      if (ATpPGH[i]) hi_p[i]++;
      if (ATmPGH[i]) hi_m[i]++;
      if (ATpPGH[i] && !prev_p[i]) rise_p[i]++;
    end
    if ((ATpPGH & ATmPGH) != '0) both_hi++;
    prev_p = ATpPGH;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge CLOCKH);
    @(negedge CLOCKH);
    rst_n  = 1'b1;
    cyc    = 0;
    prev_p = '0;
    clear_stats();
  endtask

  initial begin
    en = 1'b1; zero_req = 1'b0; ang_in = '0; rst_n = 1'b0;
    #2;
    chk("rst_p", 64'(ATpPGH), 64'h0);
    chk("rst_mirror", 64'(mirror), 64'h0);
    chk("rst_trk", 64'(trk), 64'h0);

    // Idle
    do_reset();
    step();
    chk("idle_trk", 64'(trk), 64'h7);
    repeat (99) step();
    chk("idle_pulses", 64'(hi_p[0]+hi_p[1]+hi_p[2]+hi_m[0]+hi_m[1]+hi_m[2]), 64'd0);
    chk("idle_mirror", 64'(mirror), 64'h0);

    // Plus slew on ch0 to 5
    ang_in = '0; ang_in[0*W +: W] = 16'd5;
    do_reset();
    shape_err = 0;
    for (int k = 1; k <= 72; k++) begin
      step();
      if (ATpPGH[0] !== ((k <= 60) && (((k - 1) % FR) < 2))) shape_err++;
    end
    chk("plus_shape", 64'(shape_err), 64'd0);
    chk("plus_rises", 64'(rise_p[0]), 64'd5);
    chk("plus_width", 64'(hi_p[0]), 64'd10);
    chk("plus_mirror0", 64'(mir(0)), 64'd5);
    chk("plus_quiet", 64'(hi_p[1]+hi_p[2]+hi_m[0]+hi_m[1]+hi_m[2]), 64'd0);
    chk("plus_trk", 64'(trk), 64'h7);

    // Wrap on ch1, half turn on ch2
    ang_in = '0; ang_in[1*W +: W] = 16'hFFFD; ang_in[2*W +: W] = 16'h8000;
    do_reset();
    step();
    chk("half_trk", 64'(trk[2]), 64'd0);
    shape_err = 0;
    for (int k = 2; k <= 60; k++) begin
      step();
      if (ATmPGH[1] !== ((k <= 36) && ((((k - 1) % FR) == 4) || (((k - 1) % FR) == 5))))
        shape_err++;
      if (k == 9) begin
        chk("half_first_p", 64'(ATpPGH[2]), 64'd1);
        chk("half_first_m", 64'(ATmPGH[2]), 64'd0);
      end
    end
    chk("wrap_shape", 64'(shape_err), 64'd0);
    chk("wrap_mirror1", 64'(mir(1)), 64'hFFFD);
    chk("wrap_no_plus1", 64'(hi_p[1]), 64'd0);
    chk("half_mirror2", 64'(mir(2)), 64'd5);
    chk("half_no_minus2", 64'(hi_m[2]), 64'd0);
    chk("wrap_trk", 64'(trk), 64'h3);

    // Zero during a high pulse, then re-slew to 100
    ang_in = '0; ang_in[0*W +: W] = 16'd100;
    do_reset();
    repeat (25) step();
    chk("zero_pre_p", 64'(ATpPGH[0]), 64'd1);
    chk("zero_pre_mirror0", 64'(mir(0)), 64'd3);
    zero_req = 1'b1;
    step();
    chk("zero_trunc_p", 64'(ATpPGH[0]), 64'd0);
    chk("zero_mirror", 64'(mirror), 64'h0);
    clear_stats();
    repeat (30) step();
    chk("zero_hold_pulses", 64'(hi_p[0]+hi_p[1]+hi_p[2]+hi_m[0]+hi_m[1]+hi_m[2]), 64'd0);
    chk("zero_hold_mirror", 64'(mirror), 64'h0);
    chk("zero_trk", 64'(trk), 64'h6);
    zero_req = 1'b0;
    clear_stats();
    repeat (1210) step();
    chk("reslew_mirror0", 64'(mir(0)), 64'd100);
    chk("reslew_rises", 64'(rise_p[0]), 64'd100);
    chk("reslew_width", 64'(hi_p[0]), 64'd200);

    // Enable gating on ch1 with error 10
    ang_in = '0; ang_in[1*W +: W] = 16'd10;
    en = 1'b0;
    do_reset();
    repeat (40) step();
    chk("en_off_pulses", 64'(hi_p[0]+hi_p[1]+hi_p[2]+hi_m[0]+hi_m[1]+hi_m[2]), 64'd0);
    chk("en_off_mirror", 64'(mirror), 64'h0);
    chk("en_off_trk", 64'(trk), 64'h5);
    en = 1'b1;
    step();
    chk("en_on_p1", 64'(ATpPGH[1]), 64'd1);
    chk("en_on_mirror1", 64'(mir(1)), 64'd1);
    en = 1'b0;
    step();
    chk("en_complete_p1", 64'(ATpPGH[1]), 64'd1);
    step();
    chk("en_end_p1", 64'(ATpPGH[1]), 64'd0);
    clear_stats();
    repeat (24) step();
    chk("en_off2_pulses", 64'(hi_p[1]), 64'd0);
    chk("en_off2_mirror1", 64'(mir(1)), 64'd1);
    en = 1'b1;

    // Async reset while ch0 pulse is high
    ang_in = '0; ang_in[0*W +: W] = 16'd5;
    do_reset();
    step();
    chk("ar_pre_p", 64'(ATpPGH[0]), 64'd1);
    chk("ar_pre_trk", 64'(trk), 64'h6);
    #2;
    rst_n = 1'b0;
    #2;
    chk("ar_p", 64'(ATpPGH), 64'h0);
    chk("ar_m", 64'(ATmPGH), 64'h0);
    chk("ar_mirror", 64'(mirror), 64'h0);
    chk("ar_trk", 64'(trk), 64'h0);
    @(negedge CLOCKH);
    rst_n = 1'b1;
    prev_p = '0;
    step();
    chk("ar_restart_p", 64'(ATpPGH[0]), 64'd1);
    chk("ar_restart_mirror0", 64'(mir(0)), 64'd1);

    chk("never_both_high", 64'(both_hi), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
